// File: rtl/bls_pipe_sub.sv
// bls_pipe_sub: two-stage borrow-lookahead subtractor, diff = a - b - bin; BLS_FLAGS_EN adds zero/neg/ovf.
// Latency 2 cycles at 1 op/cycle; a stalled output holds both stages, in_ready falls only when both are full.
module bls_pipe_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef BLS_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int HALF = WIDTH / 2;

  // Returns {borrow_out, diff} for one half; 4-bit groups are flattened, groups ripple.
  function automatic logic [HALF:0] sub_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            bi);
    logic [HALF-1:0] g, p, d;
    logic [HALF:0]   bor;
    logic [3:0]      gg, pp;
    logic            c;
    g      = ~x & y;
    p      = ~(x ^ y);
    bor    = '0;
    bor[0] = bi;
    for (int k = 0; k < HALF / 4; k++) begin
      gg = g[4*k +: 4];
      pp = p[4*k +: 4];
      c  = bor[4*k];
      bor[4*k+1] = gg[0] | (pp[0] & c);
      bor[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
      bor[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & c);
      bor[4*k+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]) | (pp[3] & pp[2] & pp[1] & pp[0] & c);
    end
    d = x ^ y ^ bor[HALF-1:0];
    return {bor[HALF], d};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_dlo_q, s1_dlo_d;
  logic            s1_bmid_q, s1_bmid_d;
  logic [HALF-1:0] s1_ahi_q, s1_ahi_d;
  logic [HALF-1:0] s1_bhi_q, s1_bhi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef BLS_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
`endif

  logic            s2_acc, in_acc;
  logic [HALF:0]   lo_res, hi_res;
  logic [WIDTH-1:0] diff_new;

  always_comb begin
    s2_acc   = !s2_valid_q || out_ready;
    // Reset forces readiness so upstream never sees a stall across reset.
    in_ready = reset || !s1_valid_q || s2_acc;
    in_acc   = in_valid && in_ready && !reset;
    lo_res   = sub_half(a[HALF-1:0], b[HALF-1:0], bin);
    hi_res   = sub_half(s1_ahi_q, s1_bhi_q, s1_bmid_q);
    diff_new = {hi_res[HALF-1:0], s1_dlo_q};

    s1_valid_d = s1_valid_q;
    s1_dlo_d   = s1_dlo_q;
    s1_bmid_d  = s1_bmid_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
`ifdef BLS_FLAGS_EN
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
`endif

    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_dlo_d   = lo_res[HALF-1:0];
      s1_bmid_d  = lo_res[HALF];
      s1_ahi_d   = a[WIDTH-1:HALF];
      s1_bhi_d   = b[WIDTH-1:HALF];
    end else if (s2_acc) begin
      s1_valid_d = 1'b0;
    end

    if (s2_acc) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = diff_new;
        bout_d = hi_res[HALF];
`ifdef BLS_FLAGS_EN
        zero_d = (diff_new == '0);
        neg_d  = diff_new[WIDTH-1];
        ovf_d  = (s1_ahi_q[HALF-1] ^ s1_bhi_q[HALF-1]) & (s1_ahi_q[HALF-1] ^ diff_new[WIDTH-1]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= '0;
      s1_bmid_q  <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
`ifdef BLS_FLAGS_EN
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dlo_q   <= s1_dlo_d;
      s1_bmid_q  <= s1_bmid_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
`ifdef BLS_FLAGS_EN
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef BLS_FLAGS_EN
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bls_pipe_sub.sv
// Bench for bls_pipe_sub: directed cases, backpressure, reset, then random traffic against an arithmetic model.
module tb_bls_pipe_sub;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [W-1:0] a, b, diff;
`ifdef BLS_FLAGS_EN
  logic zero, neg, ovf;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z, n, o;
  } exp_t;
  exp_t q[$];

  logic acc_t, ir_t;

  always #5 clk = ~clk;

  bls_pipe_sub #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef BLS_FLAGS_EN
    , .zero(zero), .neg(neg), .ovf(ovf)
`endif
  );

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t e;
    logic [W:0] r;
    r    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.z  = (e.d == '0);
    e.n  = e.d[W-1];
    e.o  = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ e.d[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at posedge+1, check/scoreboard at posedge+2, return at next posedge+1.
  task automatic cycle(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bi, input logic ordy, output logic acc, output logic ir);
    in_valid  = iv;
    a         = av;
    b         = bv;
    bin       = bi;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    acc = iv && in_ready;
    chk("in_ready", in_ready, W'(!(q.size() == 2 && !ordy)));
    if (q.size() == 0) begin
      chk("out_valid_idle", out_valid, 0);
    end else if (out_valid) begin
      chk("diff", diff, q[0].d);
      chk("bout", bout, q[0].bo);
`ifdef BLS_FLAGS_EN
      chk("zero", zero, q[0].z);
      chk("neg", neg, q[0].n);
      chk("ovf", ovf, q[0].o);
`endif
      if (ordy) void'(q.pop_front());
    end
    if (acc) q.push_back(model(av, bv, bi));
    @(posedge clk);
    #1;
  endtask

  task automatic op_expect(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic bi, input logic [W-1:0] ed, input logic eb,
                           input logic ez, input logic en, input logic eo);
    logic acc, ir;
    cycle(1'b1, av, bv, bi, 1'b1, acc, ir);
    chk({tag, "_acc"}, acc, 1);
    chk({tag, "_lat1"}, out_valid, 0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ir);
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
`ifdef BLS_FLAGS_EN
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_neg"}, neg, en);
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (ez && en && eo) $display("[TB] note: flag expectations unused in this build");
`endif
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ir);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int idx, stall;
    bit seen, saw_block;

    reset = 1'b1; in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; bin = 1'b1; out_ready = 1'b0;
    #1;
    chk("rst_in_ready_during", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef BLS_FLAGS_EN
    chk("rst_flags", W'({zero, neg, ovf}), 0);
`endif
    reset = 1'b0; in_valid = 1'b0;

    op_expect("t1", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    op_expect("t2a", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    op_expect("t2b", 32'h0000_0003, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    op_expect("t3a", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    op_expect("t3b", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h0246_8ACF, 1'b0, 1'b0, 1'b0, 1'b0);
    op_expect("t6a", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op_expect("t6b", 32'h0000_0007, 32'h0000_0007, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure: four ops 10-1..13-1, output stalled 3 cycles after the first result.
    idx = 0; stall = 0; seen = 0; saw_block = 0;
    for (int c = 0; c < 16; c++) begin
      logic ordy;
      if (out_valid) seen = 1;
      ordy = !(seen && stall < 3);
      if (!ordy) begin
        stall++;
        chk("bp_hold", diff, 9);
      end
      cycle(idx < 4, W'(10 + idx), 32'd1, 1'b0, ordy, acc_t, ir_t);
      if (idx < 4 && !ir_t) saw_block = 1;
      if (acc_t) idx++;
    end
    chk("bp_in_ready_drop", W'(saw_block), 1);
    chk("bp_all_sent", idx, 4);
    chk("bp_drained", q.size(), 0);

    // Reset with two ops in flight: neither may ever come out.
    cycle(1'b1, 32'd100, 32'd1, 1'b0, 1'b0, acc_t, ir_t);
    cycle(1'b1, 32'd200, 32'd1, 1'b0, 1'b0, acc_t, ir_t);
    chk("rm_inflight", q.size(), 2);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("rm_in_ready_during", in_ready, 1);
    @(posedge clk); #1;
    chk("rm_out_valid", out_valid, 0);
    chk("rm_in_ready", in_ready, 1);
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    for (int c = 0; c < 4; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc_t, ir_t);

    // Random traffic, then full-rate bursts with out_ready held high.
    for (int c = 0; c < 600; c++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? 32'h0000_0000 : ra;
      cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
            (c >= 400) || ($urandom_range(0, 3) != 0), acc_t, ir_t);
    end
    for (int c = 0; c < 6; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc_t, ir_t);
    chk("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
